// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Two-master AXI read arbiter in front of the ROM wrapper's read slave port.
// It grants M0 and M1 read bursts round-robin and forwards one burst at a time
// to the slave. R beats are routed back only to the granted master. Addresses
// outside the ROM window are answered locally with DECERR bursts.
//
// Ports:
//   ACLK, ARESETn              clock (rising edge), asynchronous active-low reset
//   M0_AR*/M0_R*               master 0 (instruction fetch) AR and R channels
//   M1_AR*/M1_R*               master 1 (data/DMA) AR and R channels
//   S_AR*/S_R*                 slave-side AR and R channels toward the ROM wrapper
module rom_read_arbiter #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LEN_W    = 4,
    parameter logic [15:0] ROM_BASE = 16'h0000
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // Master 0
    input  logic [ID_W-1:0]   M0_ARID,
    input  logic [ADDR_W-1:0] M0_ARAddr,
    input  logic [LEN_W-1:0]  M0_ARLen,
    input  logic [2:0]        M0_ARSize,
    input  logic [1:0]        M0_ARBurst,
    input  logic              M0_ARValid,
    output logic              M0_ARReady,
    output logic [ID_W-1:0]   M0_RID,
    output logic [DATA_W-1:0] M0_RData,
    output logic [1:0]        M0_RResp,
    output logic              M0_RLast,
    output logic              M0_RValid,
    input  logic              M0_RReady,
    // Master 1
    input  logic [ID_W-1:0]   M1_ARID,
    input  logic [ADDR_W-1:0] M1_ARAddr,
    input  logic [LEN_W-1:0]  M1_ARLen,
    input  logic [2:0]        M1_ARSize,
    input  logic [1:0]        M1_ARBurst,
    input  logic              M1_ARValid,
    output logic              M1_ARReady,
    output logic [ID_W-1:0]   M1_RID,
    output logic [DATA_W-1:0] M1_RData,
    output logic [1:0]        M1_RResp,
    output logic              M1_RLast,
    output logic              M1_RValid,
    input  logic              M1_RReady,
    // Slave (ROM wrapper)
    output logic [ID_W-1:0]   S_ARID,
    output logic [ADDR_W-1:0] S_ARAddr,
    output logic [LEN_W-1:0]  S_ARLen,
    output logic [2:0]        S_ARSize,
    output logic [1:0]        S_ARBurst,
    output logic              S_ARValid,
    input  logic              S_ARReady,
    input  logic [ID_W-1:0]   S_RID,
    input  logic [DATA_W-1:0] S_RData,
    input  logic [1:0]        S_RResp,
    input  logic              S_RLast,
    input  logic              S_RValid,
    output logic              S_RReady
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;

    state_e              r_state;
    logic                r_rr;
    logic                r_gnt;
    logic [LEN_W-1:0]    r_cnt;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;

    logic                w_idle;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_ar_hs;
    logic [ID_W-1:0]     w_ar_id;
    logic [ADDR_W-1:0]   w_ar_addr;
    logic [LEN_W-1:0]    w_ar_len;
    logic [2:0]          w_ar_size;
    logic [1:0]          w_ar_burst;
    logic                w_in_rom;
    logic                w_s_rready;
    logic                w_gnt_rready;
    logic                w_err_last;

    // Gating with ARESETn keeps both ARReady low while reset is held, even if a
    // master is already presenting a request.
    assign w_idle   = (r_state == StIdle) && ARESETn;
    // Contention resolved by rr: 0 favours M0, 1 favours M1.
    assign w_grant0 = w_idle && M0_ARValid && (!M1_ARValid || !r_rr);
    assign w_grant1 = w_idle && M1_ARValid && (!M0_ARValid || r_rr);
    assign w_ar_hs  = w_grant0 || w_grant1;

    assign M0_ARReady = w_grant0;
    assign M1_ARReady = w_grant1;

    assign w_ar_id    = w_grant1 ? M1_ARID    : M0_ARID;
    assign w_ar_addr  = w_grant1 ? M1_ARAddr  : M0_ARAddr;
    assign w_ar_len   = w_grant1 ? M1_ARLen   : M0_ARLen;
    assign w_ar_size  = w_grant1 ? M1_ARSize  : M0_ARSize;
    assign w_ar_burst = w_grant1 ? M1_ARBurst : M0_ARBurst;
    assign w_in_rom   = (w_ar_addr[ADDR_W-1 -: 16] == ROM_BASE);

    assign w_gnt_rready = r_gnt ? M1_RReady : M0_RReady;
    assign w_s_rready   = (r_state == StData) && w_gnt_rready;
    assign w_err_last   = (r_cnt == r_len);

    assign S_RReady  = w_s_rready;
    assign S_ARValid = (r_state == StAddr);
    assign S_ARID    = r_id;
    assign S_ARAddr  = r_addr;
    assign S_ARLen   = r_len;
    assign S_ARSize  = r_size;
    assign S_ARBurst = r_burst;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= StIdle;
            r_rr    <= 1'b0;
            r_gnt   <= 1'b0;
            r_cnt   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_ar_hs) begin
                        r_id    <= w_ar_id;
                        r_addr  <= w_ar_addr;
                        r_len   <= w_ar_len;
                        r_size  <= w_ar_size;
                        r_burst <= w_ar_burst;
                        r_gnt   <= w_grant1;
                        r_cnt   <= '0;
                        r_state <= w_in_rom ? StAddr : StErr;
                    end
                end
                StAddr: begin
                    if (S_ARReady) begin
                        r_state <= StData;
                    end
                end
                StData: begin
                    if (S_RValid && w_s_rready && S_RLast) begin
                        r_state <= StIdle;
                        r_rr    <= ~r_gnt;
                    end
                end
                StErr: begin
                    // RValid is always high here, so RReady alone completes a beat.
                    if (w_gnt_rready) begin
                        if (w_err_last) begin
                            r_state <= StIdle;
                            r_rr    <= ~r_gnt;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // R routing: pass-through from the slave in DATA, locally generated DECERR
    // beats in ERR, all zero for the non-granted master and in other states.
    always_comb begin
        M0_RID    = '0;
        M0_RData  = '0;
        M0_RResp  = '0;
        M0_RLast  = 1'b0;
        M0_RValid = 1'b0;
        M1_RID    = '0;
        M1_RData  = '0;
        M1_RResp  = '0;
        M1_RLast  = 1'b0;
        M1_RValid = 1'b0;
        case (r_state)
            StData: begin
                if (!r_gnt) begin
                    M0_RID    = S_RID;
                    M0_RData  = S_RData;
                    M0_RResp  = S_RResp;
                    M0_RLast  = S_RLast;
                    M0_RValid = S_RValid;
                end else begin
                    M1_RID    = S_RID;
                    M1_RData  = S_RData;
                    M1_RResp  = S_RResp;
                    M1_RLast  = S_RLast;
                    M1_RValid = S_RValid;
                end
            end
            StErr: begin
                if (!r_gnt) begin
                    M0_RID    = r_id;
                    M0_RResp  = 2'b11;
                    M0_RLast  = w_err_last;
                    M0_RValid = 1'b1;
                end else begin
                    M1_RID    = r_id;
                    M1_RResp  = 2'b11;
                    M1_RLast  = w_err_last;
                    M1_RValid = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter with a simple ROM slave model and a
// per-master scoreboard of expected R beats.
module tb_rom_read_arbiter;

    logic        ACLK;
    logic        ARESETn;
    logic [3:0]  M0_ARID, M1_ARID, S_ARID;
    logic [31:0] M0_ARAddr, M1_ARAddr, S_ARAddr;
    logic [3:0]  M0_ARLen, M1_ARLen, S_ARLen;
    logic [2:0]  M0_ARSize, M1_ARSize, S_ARSize;
    logic [1:0]  M0_ARBurst, M1_ARBurst, S_ARBurst;
    logic        M0_ARValid, M1_ARValid, S_ARValid;
    logic        M0_ARReady, M1_ARReady, S_ARReady;
    logic [3:0]  M0_RID, M1_RID, S_RID;
    logic [31:0] M0_RData, M1_RData, S_RData;
    logic [1:0]  M0_RResp, M1_RResp, S_RResp;
    logic        M0_RLast, M1_RLast, S_RLast;
    logic        M0_RValid, M1_RValid, S_RValid;
    logic        M0_RReady, M1_RReady, S_RReady;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last0_cyc = -10;
    int last1_cyc = -10;
    int stall0 = 0;
    int s_ar_seen = 0;
    bit err_watch = 0;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    rom_read_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_ARID(M0_ARID), .M0_ARAddr(M0_ARAddr), .M0_ARLen(M0_ARLen),
        .M0_ARSize(M0_ARSize), .M0_ARBurst(M0_ARBurst), .M0_ARValid(M0_ARValid),
        .M0_ARReady(M0_ARReady), .M0_RID(M0_RID), .M0_RData(M0_RData),
        .M0_RResp(M0_RResp), .M0_RLast(M0_RLast), .M0_RValid(M0_RValid),
        .M0_RReady(M0_RReady),
        .M1_ARID(M1_ARID), .M1_ARAddr(M1_ARAddr), .M1_ARLen(M1_ARLen),
        .M1_ARSize(M1_ARSize), .M1_ARBurst(M1_ARBurst), .M1_ARValid(M1_ARValid),
        .M1_ARReady(M1_ARReady), .M1_RID(M1_RID), .M1_RData(M1_RData),
        .M1_RResp(M1_RResp), .M1_RLast(M1_RLast), .M1_RValid(M1_RValid),
        .M1_RReady(M1_RReady),
        .S_ARID(S_ARID), .S_ARAddr(S_ARAddr), .S_ARLen(S_ARLen),
        .S_ARSize(S_ARSize), .S_ARBurst(S_ARBurst), .S_ARValid(S_ARValid),
        .S_ARReady(S_ARReady), .S_RID(S_RID), .S_RData(S_RData),
        .S_RResp(S_RResp), .S_RLast(S_RLast), .S_RValid(S_RValid),
        .S_RReady(S_RReady)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [31:0] addr, input int beat);
        return 32'hC0DE_0000 ^ (addr + 32'(beat) * 32'd4);
    endfunction

    // ROM slave model: answers one burst at a time, OKAY responses.
    bit          s_arready_en = 1'b1;
    logic        s_busy;
    logic [3:0]  s_cnt, s_len, s_id;
    logic [31:0] s_addr;

    assign S_ARReady = s_arready_en && !s_busy;
    assign S_RValid  = s_busy;
    assign S_RID     = s_busy ? s_id : 4'h0;
    assign S_RData   = s_busy ? rom_word(s_addr, int'(s_cnt)) : 32'h0;
    assign S_RResp   = 2'b00;
    assign S_RLast   = s_busy && (s_cnt == s_len);

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            s_busy <= 1'b0;
            s_cnt  <= 4'h0;
            s_len  <= 4'h0;
            s_id   <= 4'h0;
            s_addr <= 32'h0;
        end else if (!s_busy) begin
            if (S_ARValid && S_ARReady) begin
                s_busy <= 1'b1;
                s_cnt  <= 4'h0;
                s_len  <= S_ARLen;
                s_id   <= S_ARID;
                s_addr <= S_ARAddr;
            end
        end else if (S_RReady) begin
            if (s_cnt == s_len) s_busy <= 1'b0;
            else s_cnt <= s_cnt + 4'h1;
        end
    end

    // Scoreboard monitor: pops expected beats on each master R handshake, checks
    // stability under back-pressure and idle R fields.
    logic        p0_v, p0_r, p1_v, p1_r;
    logic [38:0] p0_bus, p1_bus;
    beat_t       b;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            p0_v = 1'b0; p0_r = 1'b0; p1_v = 1'b0; p1_r = 1'b0;
        end else begin
            if (M0_RValid && M0_RReady) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL m0_unexpected_beat: got %h want none",
                             {M0_RID, M0_RData, M0_RResp, M0_RLast});
                end else begin
                    b = q0.pop_front();
                    if ({M0_RID, M0_RData, M0_RResp, M0_RLast} !== b) begin
                        bad++;
                        $display("FAIL m0_beat: got %h want %h",
                                 {M0_RID, M0_RData, M0_RResp, M0_RLast}, b);
                    end
                end
                if (M0_RLast) last0_cyc = cyc;
            end
            if (M1_RValid && M1_RReady) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL m1_unexpected_beat: got %h want none",
                             {M1_RID, M1_RData, M1_RResp, M1_RLast});
                end else begin
                    b = q1.pop_front();
                    if ({M1_RID, M1_RData, M1_RResp, M1_RLast} !== b) begin
                        bad++;
                        $display("FAIL m1_beat: got %h want %h",
                                 {M1_RID, M1_RData, M1_RResp, M1_RLast}, b);
                    end
                end
                if (M1_RLast) last1_cyc = cyc;
            end
            if (p0_v && !p0_r) begin
                total++;
                if (!M0_RValid || {M0_RID, M0_RData, M0_RResp, M0_RLast} !== p0_bus) begin
                    bad++;
                    $display("FAIL m0_stall_stable: got v=%b %h want v=1 %h", M0_RValid,
                             {M0_RID, M0_RData, M0_RResp, M0_RLast}, p0_bus);
                end
            end
            if (p1_v && !p1_r) begin
                total++;
                if (!M1_RValid || {M1_RID, M1_RData, M1_RResp, M1_RLast} !== p1_bus) begin
                    bad++;
                    $display("FAIL m1_stall_stable: got v=%b %h want v=1 %h", M1_RValid,
                             {M1_RID, M1_RData, M1_RResp, M1_RLast}, p1_bus);
                end
            end
            if (!M0_RValid && {M0_RID, M0_RData, M0_RResp, M0_RLast} !== 39'h0) begin
                total++; bad++;
                $display("FAIL m0_idle_fields: got %h want 0",
                         {M0_RID, M0_RData, M0_RResp, M0_RLast});
            end
            if (!M1_RValid && {M1_RID, M1_RData, M1_RResp, M1_RLast} !== 39'h0) begin
                total++; bad++;
                $display("FAIL m1_idle_fields: got %h want 0",
                         {M1_RID, M1_RData, M1_RResp, M1_RLast});
            end
            if (M0_RValid && !M0_RReady) stall0++;
            if (err_watch && S_ARValid) s_ar_seen++;
            p0_v = M0_RValid; p0_r = M0_RReady; p0_bus = {M0_RID, M0_RData, M0_RResp, M0_RLast};
            p1_v = M1_RValid; p1_r = M1_RReady; p1_bus = {M1_RID, M1_RData, M1_RResp, M1_RLast};
        end
    end

    task automatic push_beats(input int m, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len);
        beat_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.id = id;
            if (addr[31:16] != 16'h0000) begin
                e.data = 32'h0;
                e.resp = 2'b11;
            end else begin
                e.data = rom_word(addr, i);
                e.resp = 2'b00;
            end
            e.last = (i == int'(len));
            if (m == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic set_req(input int m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len);
        if (m == 0) begin
            M0_ARID = id; M0_ARAddr = addr; M0_ARLen = len;
            M0_ARSize = 3'b010; M0_ARBurst = 2'b01; M0_ARValid = 1'b1;
        end else begin
            M1_ARID = id; M1_ARAddr = addr; M1_ARLen = len;
            M1_ARSize = 3'b010; M1_ARBurst = 2'b01; M1_ARValid = 1'b1;
        end
    endtask

    // Returns #1 after the accepting edge, i.e. early in cycle T+1.
    task automatic issue(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, output bit ok);
        @(posedge ACLK); #1;
        set_req(m, id, addr, len);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge ACLK);
            if ((m == 0) ? M0_ARReady : M1_ARReady) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge ACLK); #1;
        if (m == 0) M0_ARValid = 1'b0;
        else M1_ARValid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge ACLK); #2;
            if (q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        M0_ARValid = 1'b0; M1_ARValid = 1'b0;
        M0_RReady = 1'b1; M1_RReady = 1'b1;
        s_arready_en = 1'b1;
        repeat (2) @(posedge ACLK);
        q0.delete(); q1.delete();
        #2 ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        ARESETn = 1'b0;
        M0_ARID = 4'h0; M0_ARAddr = 32'h0; M0_ARLen = 4'h0; M0_ARSize = 3'h0; M0_ARBurst = 2'h0;
        M1_ARID = 4'h0; M1_ARAddr = 32'h0; M1_ARLen = 4'h0; M1_ARSize = 3'h0; M1_ARBurst = 2'h0;
        M0_RReady = 1'b1; M1_RReady = 1'b1;
        M0_ARValid = 1'b1; M1_ARValid = 1'b1;
        @(negedge ACLK);
        total++;
        if ({M0_ARReady, M1_ARReady, S_ARValid, S_RReady, M0_RValid, M1_RValid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_valid_ready: got %b want 000000",
                     {M0_ARReady, M1_ARReady, S_ARValid, S_RReady, M0_RValid, M1_RValid});
        end
        total++;
        if ({S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst} !== 45'h0) begin
            bad++;
            $display("FAIL reset_s_ar_fields: got %h want 0",
                     {S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst});
        end
        total++;
        if ({M0_RID, M0_RData, M0_RResp, M0_RLast, M1_RID, M1_RData, M1_RResp, M1_RLast}
            !== 78'h0) begin
            bad++;
            $display("FAIL reset_r_fields: got nonzero want 0");
        end
        M0_ARValid = 1'b0; M1_ARValid = 1'b0;
        do_reset();
        ok = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        push_beats(0, 4'h5, 32'h0000_0010, 4'd3);
        issue(0, 4'h5, 32'h0000_0010, 4'd3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_accept: got timeout want M0_ARReady"); end
        @(negedge ACLK);
        total++;
        if ({S_ARValid, S_ARAddr, S_ARID, S_ARLen} !== {1'b1, 32'h10, 4'h5, 4'd3}) begin
            bad++;
            $display("FAIL single_s_ar: got %b %h %h %h want 1 00000010 5 3",
                     S_ARValid, S_ARAddr, S_ARID, S_ARLen);
        end
        total++;
        if ({S_ARSize, S_ARBurst, M0_ARReady, M1_ARReady} !== {3'b010, 2'b01, 2'b00}) begin
            bad++;
            $display("FAIL single_ar_misc: got %b %b %b%b want 010 01 00",
                     S_ARSize, S_ARBurst, M0_ARReady, M1_ARReady);
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_drain: got %0d left want 0", q0.size()); end
        @(negedge ACLK);
        total++;
        if ({S_ARValid, S_RReady, M0_RValid, M1_RValid} !== 4'b0) begin
            bad++;
            $display("FAIL single_idle_after: got %b want 0000",
                     {S_ARValid, S_RReady, M0_RValid, M1_RValid});
        end
    endtask

    task automatic both_req(input int win,
                            input logic [3:0] id0, input logic [31:0] a0, input logic [3:0] l0,
                            input logic [3:0] id1, input logic [31:0] a1, input logic [3:0] l1);
        bit seen;
        int gcyc;
        int wlast;
        push_beats(0, id0, a0, l0);
        push_beats(1, id1, a1, l1);
        @(posedge ACLK); #1;
        set_req(0, id0, a0, l0);
        set_req(1, id1, a1, l1);
        @(negedge ACLK);
        total++;
        if ({M0_ARReady, M1_ARReady} !== ((win == 0) ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL rr_first_grant: got %b%b want winner M%0d", M0_ARReady, M1_ARReady, win);
        end
        @(posedge ACLK); #1;
        if (win == 0) M0_ARValid = 1'b0;
        else M1_ARValid = 1'b0;
        seen = 1'b0;
        gcyc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge ACLK);
            if ((win == 0) ? M1_ARReady : M0_ARReady) begin
                seen = 1'b1;
                gcyc = cyc;
                break;
            end
        end
        @(posedge ACLK); #1;
        M0_ARValid = 1'b0; M1_ARValid = 1'b0;
        wlast = (win == 0) ? last0_cyc : last1_cyc;
        total++;
        if (!seen || gcyc != wlast + 1) begin
            bad++;
            $display("FAIL rr_second_grant: got seen=%0d cycle %0d want cycle %0d",
                     seen, gcyc, wlast + 1);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        both_req(0, 4'h1, 32'h0000_0100, 4'd1, 4'h2, 32'h0000_0200, 4'd2);
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_drain_a: got pending beats want none"); end
        // Serve M0 alone so rr points at M1 for the next contention.
        push_beats(0, 4'h3, 32'h0000_0300, 4'd0);
        issue(0, 4'h3, 32'h0000_0300, 4'd0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_m0_alone: got timeout want accept"); end
        drain(ok);
        both_req(1, 4'h6, 32'h0000_0500, 4'd0, 4'h4, 32'h0000_0400, 4'd1);
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_drain_b: got pending beats want none"); end
    endtask

    task automatic test_decerr();
        bit ok;
        s_ar_seen = 0;
        err_watch = 1'b1;
        push_beats(1, 4'h9, 32'h1000_0000, 4'd2);
        issue(1, 4'h9, 32'h1000_0000, 4'd2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL decerr_accept: got timeout want accept"); end
        @(negedge ACLK);
        total++;
        if ({M1_RValid, M1_RResp} !== 3'b111) begin
            bad++;
            $display("FAIL decerr_first_beat: got v=%b resp=%b want v=1 resp=11",
                     M1_RValid, M1_RResp);
        end
        drain(ok);
        err_watch = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL decerr_drain: got %0d left want 0", q1.size()); end
        total++;
        if (s_ar_seen != 0) begin
            bad++;
            $display("FAIL decerr_no_s_ar: got %0d cycles want 0", s_ar_seen);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit stalled[16];
        int hs;
        int stall;
        for (int i = 0; i < 16; i++) stalled[i] = 1'b0;
        hs = 0;
        stall = 0;
        stall0 = 0;
        push_beats(0, 4'h3, 32'h0000_0040, 4'd15);
        issue(0, 4'h3, 32'h0000_0040, 4'd15, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_accept: got timeout want accept"); end
        for (int c = 0; c < 300 && hs < 16; c++) begin
            @(posedge ACLK); #1;
            if (stall > 0) begin
                M0_RReady = 1'b0;
                stall--;
            end else if (M0_RValid && (hs == 0 || hs == 7 || hs == 15) && !stalled[hs]) begin
                stalled[hs] = 1'b1;
                stall = 2;
                M0_RReady = 1'b0;
            end else begin
                M0_RReady = 1'b1;
            end
            @(negedge ACLK);
            if (M0_RValid && M0_RReady) hs++;
        end
        @(posedge ACLK); #1;
        M0_RReady = 1'b1;
        total++;
        if (hs != 16 || q0.size() != 0) begin
            bad++;
            $display("FAIL stall_beats: got %0d beats %0d left want 16 beats 0 left", hs, q0.size());
        end
        total++;
        if (stall0 != 9) begin
            bad++;
            $display("FAIL stall_cycles: got %0d want 9", stall0);
        end
    endtask

    task automatic test_arready_hold();
        bit ok;
        bit seen;
        int gcyc;
        s_arready_en = 1'b0;
        push_beats(0, 4'h4, 32'h0000_0080, 4'd0);
        push_beats(1, 4'h6, 32'h0000_0300, 4'd0);
        issue(0, 4'h4, 32'h0000_0080, 4'd0, ok);
        set_req(1, 4'h6, 32'h0000_0300, 4'd0);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_accept: got timeout want accept"); end
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            total++;
            if ({S_ARValid, S_ARAddr, S_ARID, M0_ARReady, M1_ARReady}
                !== {1'b1, 32'h80, 4'h4, 2'b00}) begin
                bad++;
                $display("FAIL hold_ar_stable: got %b %h %h %b%b want 1 00000080 4 00",
                         S_ARValid, S_ARAddr, S_ARID, M0_ARReady, M1_ARReady);
            end
        end
        @(posedge ACLK); #1;
        s_arready_en = 1'b1;
        seen = 1'b0;
        gcyc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge ACLK);
            if (M1_ARReady) begin
                seen = 1'b1;
                gcyc = cyc;
                break;
            end
        end
        @(posedge ACLK); #1;
        M1_ARValid = 1'b0;
        total++;
        if (!seen || gcyc != last0_cyc + 1) begin
            bad++;
            $display("FAIL hold_m1_after: got seen=%0d cycle %0d want cycle %0d",
                     seen, gcyc, last0_cyc + 1);
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_drain: got pending beats want none"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int hs;
        hs = 0;
        push_beats(0, 4'h2, 32'h0000_0020, 4'd7);
        issue(0, 4'h2, 32'h0000_0020, 4'd7, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_accept: got timeout want accept"); end
        for (int c = 0; c < 50 && hs < 2; c++) begin
            @(negedge ACLK);
            if (M0_RValid && M0_RReady) hs++;
        end
        @(posedge ACLK); #3;
        ARESETn = 1'b0;
        #1;
        total++;
        if ({M0_ARReady, M1_ARReady, S_ARValid, S_RReady, M0_RValid, M1_RValid} !== 6'b0) begin
            bad++;
            $display("FAIL rmid_outputs: got %b want 000000",
                     {M0_ARReady, M1_ARReady, S_ARValid, S_RReady, M0_RValid, M1_RValid});
        end
        q0.delete();
        q1.delete();
        @(posedge ACLK); #2;
        ARESETn = 1'b1;
        push_beats(1, 4'h7, 32'h0000_0400, 4'd1);
        issue(1, 4'h7, 32'h0000_0400, 4'd1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_m1_accept: got timeout want accept"); end
        @(negedge ACLK);
        total++;
        if ({S_ARValid, S_ARID, S_ARAddr} !== {1'b1, 4'h7, 32'h400}) begin
            bad++;
            $display("FAIL rmid_s_ar: got %b %h %h want 1 7 00000400", S_ARValid, S_ARID, S_ARAddr);
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_drain: got pending beats want none"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_decerr();
        test_stall();
        test_arready_hold();
        test_reset_mid();
        repeat (2) @(posedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
